// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch-unit state encoding, opcode field width,
// reserved opcodes and the sequential PC increment.
// Imported by the fetch unit and its next-PC helper.
package cpu_pkg;

  typedef enum logic [1:0] {
    IFU_FETCH  = 2'd0,
    IFU_EXEC   = 2'd1,
    IFU_HALTED = 2'd2
  } ifu_state_t;

  localparam int         OPCODE_W = 6;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] OP_NOP   = 6'b111110;
  localparam int         PC_STEP  = 4;

endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC select: halt holds pc, a taken branch jumps to the word-aligned
// target, otherwise pc + 4 (wraps modulo 2^ADDR_W). Purely combinational.
// Ports: i_pc, i_branch_taken, i_branch_target, i_halt -> o_next_pc.
module ifu_next_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] i_pc,
  input  logic              i_branch_taken,
  input  logic [ADDR_W-1:0] i_branch_target,
  input  logic              i_halt,
  output logic [ADDR_W-1:0] o_next_pc
);

  // Misaligned targets are silently aligned down; no fault is raised.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PC_STEP - 1);

  logic [ADDR_W-1:0] w_seq_pc;
  logic [ADDR_W-1:0] w_tgt_pc;

  assign w_seq_pc = i_pc + ADDR_W'(PC_STEP);
  assign w_tgt_pc = i_branch_target & ALIGN_MASK;

  // Halt has priority over a simultaneous branch.
  always_comb begin
    o_next_pc = w_seq_pc;
    if (i_halt) begin
      o_next_pc = i_pc;
    end else if (i_branch_taken) begin
      o_next_pc = w_tgt_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Multi-cycle fetch stage: holds the PC, fetches over a req/ready handshake,
// latches the word into the instruction register and feeds the opcode to decode.
// Latency: >=1 cycle fetch (ready in first req cycle), then EXEC until exec_done.
// Backpressure: imem_req/imem_addr held stable until imem_ready; EXEC waits for exec_done.
// Ports: clk, reset (async active-low); imem_req/imem_addr/imem_rdata/imem_ready;
//        instr/opcode/instr_valid/pc/pc_plus4 to decode+execute;
//        exec_done/branch_taken/branch_target/halt from execute; halted; retire_count.
// Optional: define IFU_RETIRE_COUNT_EN to build the retired-instruction counter;
//           otherwise retire_count is tied to zero.
module instruction_fetch_unit
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  output logic                imem_req,
  output logic [ADDR_W-1:0]   imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPCODE_W-1:0] opcode,
  output logic                instr_valid,
  output logic [ADDR_W-1:0]   pc,
  output logic [ADDR_W-1:0]   pc_plus4,
  input  logic                exec_done,
  input  logic                branch_taken,
  input  logic [ADDR_W-1:0]   branch_target,
  input  logic                halt,
  output logic                halted,
  output logic [31:0]         retire_count
);

  ifu_state_t         r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_imem_req;
  logic               r_instr_valid;
  logic               r_halted;
  logic [ADDR_W-1:0]  w_next_pc;

  ifu_next_pc #(
    .ADDR_W(ADDR_W)
  ) u_next_pc (
    .i_pc           (r_pc),
    .i_branch_taken (branch_taken),
    .i_branch_target(branch_target),
    .i_halt         (halt),
    .o_next_pc      (w_next_pc)
  );

  // Outputs are registered and updated alongside the state they describe.
  // r_imem_req is low in the first FETCH cycle after reset and rises on the
  // first edge; a ready is only accepted while the request is actually out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IFU_FETCH;
      r_pc          <= RESET_PC;
      r_instr       <= '0;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_halted      <= 1'b0;
    end else begin
      case (r_state)
        IFU_FETCH: begin
          if (r_imem_req && imem_ready) begin
            r_instr       <= imem_rdata;
            r_state       <= IFU_EXEC;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
          end else begin
            r_imem_req    <= 1'b1;
          end
        end
        IFU_EXEC: begin
          if (exec_done) begin
            r_instr_valid <= 1'b0;
            if (halt) begin
              r_state    <= IFU_HALTED;
              r_halted   <= 1'b1;
            end else begin
              r_pc       <= w_next_pc;
              r_state    <= IFU_FETCH;
              r_imem_req <= 1'b1;
            end
          end
        end
        IFU_HALTED: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_halted      <= 1'b1;
        end
        default: begin
          r_state       <= IFU_FETCH;
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef IFU_RETIRE_COUNT_EN
  logic [31:0] r_retire_count;

  // Every completed instruction retires, including the halt itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retire_count <= '0;
    end else if (r_state == IFU_EXEC && exec_done) begin
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign retire_count = r_retire_count;
`else
  assign retire_count = '0;
`endif

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign opcode      = r_instr[INSTR_W-1 -: OPCODE_W];
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + ADDR_W'(PC_STEP);
  assign halted      = r_halted;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: a hand-computed table of
// fetch/execute transactions, randomized transactions against a behavioural
// model, halt hold-off and reset during an outstanding fetch.
module tb_instruction_fetch_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        exec_done;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        halt;
  logic        halted;
  logic [31:0] retire_count;

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .instr        (instr),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .exec_done    (exec_done),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .halt         (halt),
    .halted       (halted),
    .retire_count (retire_count)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_retired;   // model: instructions retired since reset

  typedef struct {
    logic [31:0] rdata;
    int unsigned wait_c;   // cycles imem_ready stays low
    int unsigned exec_d;   // EXEC cycles before exec_done
    logic        br;
    logic [31:0] tgt;
    logic        hlt;
    logic [31:0] addr;     // address this instruction must be fetched from
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rc();
`ifdef IFU_RETIRE_COUNT_EN
    return m_retired;
`else
    return 32'd0;
`endif
  endfunction

  // Spec rules in plain arithmetic: halt holds, branch aligns down to a
  // multiple of 4, otherwise step by 4 modulo 2^32.
  function automatic logic [31:0] model_next(input logic [31:0] a, input logic b,
                                             input logic [31:0] t, input logic h);
    if (h) return a;
    if (b) return (t / 32'd4) * 32'd4;
    return a + 32'd4;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    imem_ready    = 1'b0;
    imem_rdata    = '0;
    exec_done     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = '0;
    halt          = 1'b0;
  endtask

  // Called at a negedge; reset is asserted immediately and checked 1ns later.
  task automatic apply_reset();
    idle_inputs();
    reset = 1'b0;
    #1;
    m_retired = 0;
    chk("rst_req",     32'(imem_req), 32'd0);
    chk("rst_pc",      pc, 32'd0);
    chk("rst_instr",   instr, 32'd0);
    chk("rst_valid",   32'(instr_valid), 32'd0);
    chk("rst_halted",  32'(halted), 32'd0);
    chk("rst_retire",  retire_count, 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("first_req",   32'(imem_req), 32'd1);
    chk("first_addr",  imem_addr, 32'd0);
  endtask

  // One full fetch/execute transaction, starting at a negedge in FETCH.
  task automatic run_instr(input logic [31:0] rdata, input int unsigned wait_c,
                           input int unsigned exec_d, input logic br,
                           input logic [31:0] tgt, input logic hlt,
                           input logic [31:0] addr, output logic [31:0] next_addr);
    logic [5:0] exp_op;
    exp_op = rdata[31:26];
    chk("issue_req",   32'(imem_req), 32'd1);
    chk("issue_addr",  imem_addr, addr);
    chk("issue_valid", 32'(instr_valid), 32'd0);
    for (int w = 0; w < int'(wait_c); w++) begin
      imem_ready    = 1'b0;
      imem_rdata    = $urandom;
      exec_done     = 1'($urandom_range(0, 1));
      halt          = 1'($urandom_range(0, 1));
      branch_taken  = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      step();
      chk("wait_req",   32'(imem_req), 32'd1);
      chk("wait_addr",  imem_addr, addr);
      chk("wait_valid", 32'(instr_valid), 32'd0);
      chk("wait_halt",  32'(halted), 32'd0);
    end
    imem_ready = 1'b1;
    imem_rdata = rdata;
    exec_done  = 1'($urandom_range(0, 1));
    halt       = 1'($urandom_range(0, 1));
    step();
    imem_ready = 1'b0;
    exec_done  = 1'b0;
    halt       = 1'b0;
    chk("exec_valid",  32'(instr_valid), 32'd1);
    chk("exec_instr",  instr, rdata);
    chk("exec_opcode", 32'(opcode), 32'(exp_op));
    chk("exec_pc",     pc, addr);
    chk("exec_pc4",    pc_plus4, addr + 32'd4);
    chk("exec_req",    32'(imem_req), 32'd0);
    chk("exec_rc",     retire_count, exp_rc());
    for (int d = 0; d < int'(exec_d); d++) begin
      exec_done    = 1'b0;
      imem_ready   = 1'($urandom_range(0, 1));
      imem_rdata   = $urandom;
      halt         = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      step();
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, rdata);
      chk("hold_pc",    pc, addr);
      chk("hold_req",   32'(imem_req), 32'd0);
    end
    exec_done     = 1'b1;
    halt          = hlt;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = 1'($urandom_range(0, 1));
    imem_rdata    = $urandom;
    step();
    idle_inputs();
    m_retired = m_retired + 32'd1;
    next_addr = model_next(addr, br, tgt, hlt);
    if (hlt) begin
      chk("halt_flag",  32'(halted), 32'd1);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_req",   32'(imem_req), 32'd0);
      chk("halt_pc",    pc, addr);
    end else begin
      chk("next_req",   32'(imem_req), 32'd1);
      chk("next_addr",  imem_addr, next_addr);
      chk("next_valid", 32'(instr_valid), 32'd0);
      chk("next_halt",  32'(halted), 32'd0);
    end
    chk("retire_rc", retire_count, exp_rc());
  endtask

  // Halted core must ignore every input until reset.
  task automatic halt_hold(input logic [31:0] addr, input int unsigned cycles);
    for (int c = 0; c < int'(cycles); c++) begin
      imem_ready    = 1'($urandom_range(0, 1));
      imem_rdata    = $urandom;
      exec_done     = 1'($urandom_range(0, 1));
      halt          = 1'($urandom_range(0, 1));
      branch_taken  = 1'($urandom_range(0, 1));
      branch_target = $urandom;
      step();
      chk("hh_halted", 32'(halted), 32'd1);
      chk("hh_req",    32'(imem_req), 32'd0);
      chk("hh_pc",     pc, addr);
      chk("hh_valid",  32'(instr_valid), 32'd0);
      chk("hh_rc",     retire_count, exp_rc());
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] nxt;
    logic [31:0] a;

    tbl[0] = '{32'h0400_0000,       0, 0, 1'b1, 32'h0000_0010, 1'b0, 32'h0000_0000};
    tbl[1] = '{32'h0800_1234,       3, 1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0010};
    tbl[2] = '{32'hFC00_0000,       1, 0, 1'b1, 32'h0000_0103, 1'b0, 32'h0000_0014};
    tbl[3] = '{32'h0C00_0001,       0, 2, 1'b1, 32'hFFFF_FFFE, 1'b0, 32'h0000_0100};
    tbl[4] = '{32'h1000_0000,       2, 0, 1'b0, 32'h0000_0000, 1'b0, 32'hFFFF_FFFC};
    tbl[5] = '{{OP_NOP, 26'h0},     0, 0, 1'b1, 32'h0000_0020, 1'b0, 32'h0000_0000};
    tbl[6] = '{{OP_HALT, 26'h1},    0, 0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0020};

    reset = 1'b0;
    idle_inputs();
    m_retired = 0;
    step();
    apply_reset();

    // Directed table, table addresses are hand-derived constants.
    for (int i = 0; i < 7; i++) begin
      run_instr(tbl[i].rdata, tbl[i].wait_c, tbl[i].exec_d, tbl[i].br,
                tbl[i].tgt, tbl[i].hlt, tbl[i].addr, nxt);
    end
    halt_hold(32'h0000_0020, 20);

    // Reset while a request is outstanding.
    apply_reset();
    run_instr(32'h2000_0000, 0, 0, 1'b1, 32'h0000_0080, 1'b0, 32'h0, nxt);
    imem_ready = 1'b0;
    step();
    chk("mid_req_before", 32'(imem_req), 32'd1);
    chk("mid_addr_before", imem_addr, 32'h0000_0080);
    apply_reset();

    // Randomized transactions checked against the model.
    a = 32'h0;
    for (int n = 0; n < 40; n++) begin
      run_instr($urandom, $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom_range(0, 2) == 0), $urandom, 1'b0, a, nxt);
      a = nxt;
    end
    run_instr($urandom, $urandom_range(0, 2), $urandom_range(0, 2),
              1'($urandom_range(0, 1)), $urandom, 1'b1, a, nxt);
    halt_hold(a, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Multi-cycle fetch stage that sits directly upstream of the opcode decoder.
- Holds the PC and issues requests to instruction memory over a variable-latency handshake.
- Latches the returned word into the instruction register and presents instr[31:26] as the opcode to decode.
- After execute signals completion, selects the next PC (sequential or branch target) or stops on halt.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- INSTR_W, 32, instruction word width; opcode is always bits [INSTR_W-1 : INSTR_W-6].
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request, held high until imem_ready.
- imem_addr  out  ADDR_W  fetch address (= pc).
- imem_rdata  in  INSTR_W  instruction word; valid when imem_ready=1.
- imem_ready  in  1  memory completes the request this cycle.
- instr  out  INSTR_W  instruction register.
- opcode  out  6  instr[INSTR_W-1 -: 6], to decoder.
- instr_valid  out  1  instr/opcode are valid for execute.
- pc  out  ADDR_W  address of the instruction in instr.
- pc_plus4  out  ADDR_W  pc+4, used as link value for bl.
- exec_done  in  1  execute has finished the current instruction.
- branch_taken  in  1  resolved redirect, sampled with exec_done.
- branch_target  in  ADDR_W  redirect address, sampled with exec_done.
- halt  in  1  decoded halt, sampled with exec_done.
- halted  out  1  core stopped.
- retire_count  out  32  retired-instruction counter (see Optional Feature).

Behaviour:
- Reset (reset=0, asynchronous):
  - pc=RESET_PC, instr=0, state=FETCH, imem_req=0, instr_valid=0, halted=0, retire_count=0.
  - An in-flight request is abandoned immediately.
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC.
- State FETCH:
  - imem_req=1 and imem_addr=pc, held stable until imem_ready.
  - On imem_ready: instr<=imem_rdata; next state EXEC.
  - Minimum latency: 1 cycle from req to EXEC when ready is high in the first request cycle.
  - exec_done is ignored in FETCH.
- State EXEC:
  - instr_valid=1 (level) and imem_req=0; instr and pc are held.
  - On exec_done with halt=1: next state HALTED, pc unchanged; the halt counts as retired.
  - Else on exec_done: pc <= branch_taken ? {branch_target[ADDR_W-1:2],2'b00} : pc+4; next state FETCH; retire_count+1.
  - imem_ready is ignored in EXEC.
- State HALTED:
  - halted=1, instr_valid=0, imem_req=0.
  - All inputs are ignored; only reset leaves this state.
- Arithmetic:
  - pc+4 wraps modulo 2^ADDR_W (all-ones-minus-3 +4 = 0).
  - Branch target low two bits are forced to 0, with no fault.
- Simultaneous events:
  - halt=1 together with branch_taken=1: halt wins, pc unchanged.
  - exec_done in the same cycle the state enters EXEC is legal and acted on in the following edge.
- pc_plus4 is combinational from pc.

Optional Feature:
- Macro IFU_RETIRE_COUNT_EN.
- Defined: retire_count is a 32-bit counter, +1 per exec_done in EXEC (including halt), wraps at 2^32, reset to 0.
- Undefined: no counter register; retire_count tied to 0.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum ifu_state_t {IFU_FETCH, IFU_EXEC, IFU_HALTED};
  - localparams OPCODE_W=6, OP_HALT=6'b111111, OP_NOP=6'b111110, PC_STEP=4.
- One sub-module, ifu_next_pc: combinational pc, branch_taken, branch_target, halt -> next_pc.
- FSM and registers stay in the top.

Test Plan:
- Reset, with memory returning 0x04000000 with ready on the first cycle:
  - imem_addr=0 at the first req; opcode=6'b000001 in EXEC; instr_valid=1.
- Sequential fetch, with exec_done and no branch at pc=0x10:
  - next imem_addr=0x14; retire_count increments by 1 when the macro is defined.
- Memory wait, imem_ready low for 3 cycles:
  - imem_req and imem_addr stay stable for 4 cycles; instr_valid stays 0 until capture.
- Branch taken with target 0x103:
  - next imem_addr=0x100.
- halt=1 with branch_taken=1 at pc=0x20:
  - halted=1, pc stays 0x20, imem_req remains 0 for 20 cycles.
- Wrap and reset mid-fetch:
  - pc=0xFFFFFFFC with sequential exec_done gives imem_addr=0x0.
  - Asserting reset while imem_req=1 drops imem_req the same cycle; pc=RESET_PC.
